// File: rtl/fib_scr_pkg.sv
// Shared types and Gray-code helpers for the Fibonacci/Gray scrambler.
// Helpers work on a fixed maximum width; callers zero-extend and truncate.
package fib_scr_pkg;

  typedef enum logic [1:0] {
    MODE_XOR    = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_DEGRAY = 2'd2,
    MODE_RAW    = 2'd3
  } scr_mode_e;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Zero upper bits stay zero in the prefix XOR, so the truncated result is exact.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = '0;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fib_gray_scrambler_keystream.sv
// Fibonacci keystream generator: holds (f0,f1), presents f0 as the key and
// steps to (f1, f0+f1 mod 2^WIDTH) on each advance.
module fib_keystream #(
  parameter int          WIDTH = 16,
  parameter int unsigned SEED0 = 0,
  parameter int unsigned SEED1 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic             advance,
  output logic [WIDTH-1:0] key
);

  localparam logic [WIDTH-1:0] S0 = WIDTH'(SEED0);
  localparam logic [WIDTH-1:0] S1 = WIDTH'(SEED1);

  logic [WIDTH-1:0] r_f0;
  logic [WIDTH-1:0] r_f1;
  logic [WIDTH-1:0] w_f0;
  logic [WIDTH-1:0] w_f1;

  // A restart in the same cycle as an advance makes the seeds the current state.
  assign w_f0 = restart ? seed_a : r_f0;
  assign w_f1 = restart ? seed_b : r_f1;
  assign key  = w_f0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f0 <= S0;
      r_f1 <= S1;
    end else if (advance) begin
      r_f0 <= w_f1;
      r_f1 <= w_f0 + w_f1;
    end else if (restart) begin
      r_f0 <= w_f0;
      r_f1 <= w_f1;
    end
  end

endmodule

// File: rtl/fib_gray_scrambler.sv
// Streaming scrambler: per-beat Gray/de-Gray/raw transform XORed with a
// Fibonacci keystream, one registered output stage with valid/ready.
module fib_gray_scrambler
  import fib_scr_pkg::*;
#(
  parameter int          WIDTH = 16,
  parameter int unsigned SEED0 = 0,
  parameter int unsigned SEED1 = 1,
  parameter int          IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_key,
  output logic [IDX_W-1:0] out_index
);

  logic             w_accept;
  logic [WIDTH-1:0] w_key_p0;
  logic [WIDTH-1:0] w_data_p0;
  logic [IDX_W-1:0] w_idx_p0;
  scr_mode_e        w_mode_p0;

  logic             r_vld_p1;
  logic [WIDTH-1:0] r_data_p1;
  logic [WIDTH-1:0] r_key_p1;
  logic [IDX_W-1:0] r_idx_p1;
  logic [IDX_W-1:0] r_cnt;

  assign in_ready  = !r_vld_p1 || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_mode_p0 = scr_mode_e'(mode);
  assign w_idx_p0  = restart ? '0 : r_cnt;

  fib_keystream #(
    .WIDTH (WIDTH),
    .SEED0 (SEED0),
    .SEED1 (SEED1)
  ) u_keystream (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .seed_a  (seed_a),
    .seed_b  (seed_b),
    .advance (w_accept),
    .key     (w_key_p0)
  );

  always_comb begin
    w_data_p0 = in_data ^ w_key_p0;
    case (w_mode_p0)
      MODE_XOR:    w_data_p0 = in_data ^ w_key_p0;
      MODE_GRAY:   w_data_p0 = WIDTH'(bin2gray(MAX_W'(in_data))) ^ w_key_p0;
      MODE_DEGRAY: w_data_p0 = WIDTH'(gray2bin(MAX_W'(in_data ^ w_key_p0)));
      MODE_RAW:    w_data_p0 = in_data;
      default:     w_data_p0 = in_data ^ w_key_p0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_idx_p0 + IDX_W'(1);
    end else if (restart) begin
      r_cnt <= '0;
    end
  end

  // p0 -> p1: output register, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_key_p1  <= '0;
      r_idx_p1  <= '0;
    end else if (w_accept) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= w_data_p0;
      r_key_p1  <= w_key_p0;
      r_idx_p1  <= w_idx_p0;
    end else if (out_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_key   = r_key_p1;
  assign out_index = r_idx_p1;

endmodule
